uart_fifo_core: RTL and testbench

//  Next-generation UART with parametrised data width, TX/RX FIFO depth and baud divider.

---
 rtl/uart_fifo_core.sv | 357 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// UART core: TX/RX FIFOs, per-direction baud prescalers, optional parity, error flags
// and a maskable level interrupt behind a cs/wen/addr register bus.
module uart_fifo_core #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        TX,
    input  logic        RX,
    input  logic        cs,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        intr
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    function automatic logic [3:0] word_len(input logic [2:0] wlen);
        logic [4:0] n;
        n = {2'b00, wlen} + 5'd5;
        if (n > 5'(DATA_W)) n = 5'(DATA_W);
        return n[3:0];
    endfunction

    function automatic logic [DATA_W-1:0] word_mask(input logic [3:0] nb);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) m[i] = (4'(i) < nb);
        return m;
    endfunction

    logic [11:0]      ctrl_q;
    logic [DIV_W-1:0] div_q;
    logic             rx_ovf_q, frame_err_q, par_err_q;
    logic             en, rd_req, wr_req, w1c;
    logic [2:0]       sel;
    logic [4:0]       stat;
    logic             unused_bits;

    assign en          = ctrl_q[0];
    assign sel         = addr[4:2];
    assign rd_req      = cs & ~wen;
    assign wr_req      = cs & wen;
    assign w1c         = wr_req && (sel == 3'd1);
    assign unused_bits = ^{addr[31:5], addr[1:0], wdata};

    // ---------------- FIFOs ----------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]     tx_cnt_q, rx_cnt_q;
    logic              tx_push, tx_pop, tx_full, tx_nempty;
    logic              rx_push, rx_pop, rx_full, rx_nempty, rx_push_req;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    assign tx_full   = (tx_cnt_q == CW'(FIFO_DEPTH));
    assign tx_nempty = (tx_cnt_q != '0);
    assign rx_full   = (rx_cnt_q == CW'(FIFO_DEPTH));
    assign rx_nempty = (rx_cnt_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign tx_push   = wr_req && (sel == 3'd2) && (!tx_full || tx_pop);
    assign rx_pop    = rd_req && (sel == 3'd3) && rx_nempty;
    assign rx_push   = rx_push_req && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= wdata[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wp_q] <= rx_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
            rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // ---------------- TX FSM ----------------
    state_e            tx_st_q, tx_st_d;
    logic [3:0]        tx_tk_q, tx_tk_d, tx_bit_q, tx_bit_d, tx_nb_q, tx_nb_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, tx_word;
    logic              tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_s2_q, tx_s2_d;
    logic              tx_stop_q, tx_stop_d, tx_tick, tx_load;
    logic [DIV_W-1:0]  tx_div_q, tx_div_d, tx_pre_q, tx_pre_d;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_tk_d   = tx_tk_q;
        tx_bit_d  = tx_bit_q;
        tx_nb_d   = tx_nb_q;
        tx_sh_d   = tx_sh_q;
        tx_par_d  = tx_par_q;
        tx_pen_d  = tx_pen_q;
        tx_s2_d   = tx_s2_q;
        tx_stop_d = tx_stop_q;
        tx_div_d  = tx_div_q;
        tx_pre_d  = tx_pre_q;
        tx_pop    = 1'b0;
        tx_load   = 1'b0;
        tx_word   = '0;
        tx_tick   = (tx_pre_q == '0);
        if (tx_st_q != StIdle) begin
            tx_pre_d = tx_tick ? tx_div_q : tx_pre_q - 1'b1;
            if (tx_tick) tx_tk_d = tx_tk_q + 1'b1;
        end
        unique case (tx_st_q)
            StIdle: tx_load = en && tx_nempty;
            StStart: begin
                if (tx_tick && tx_tk_q == 4'd15) begin
                    tx_st_d  = StData;
                    tx_bit_d = '0;
                end
            end
            StData: begin
                if (tx_tick && tx_tk_q == 4'd15) begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == tx_nb_q - 4'd1) begin
                        tx_st_d   = tx_pen_q ? StParity : StStop;
                        tx_stop_d = 1'b0;
                    end
                end
            end
            StParity: begin
                if (tx_tick && tx_tk_q == 4'd15) begin
                    tx_st_d   = StStop;
                    tx_stop_d = 1'b0;
                end
            end
            StStop: begin
                if (tx_tick && tx_tk_q == 4'd15) begin
                    if (tx_s2_q && !tx_stop_q) tx_stop_d = 1'b1;
                    else if (en && tx_nempty)  tx_load = 1'b1;
                    else                       tx_st_d = StIdle;
                end
            end
            default: tx_st_d = StIdle;
        endcase
        // Frame configuration is captured here so register writes only affect later frames.
        if (tx_load) begin
            tx_pop   = 1'b1;
            tx_st_d  = StStart;
            tx_tk_d  = '0;
            tx_pre_d = div_q;
            tx_div_d = div_q;
            tx_nb_d  = word_len(ctrl_q[3:1]);
            tx_pen_d = ctrl_q[5];
            tx_s2_d  = ctrl_q[4];
            tx_word  = tx_mem[tx_rp_q] & word_mask(word_len(ctrl_q[3:1]));
            tx_sh_d  = tx_word;
            tx_par_d = (^tx_word) ^ ctrl_q[6];
        end
        if (!en) begin
            tx_st_d = StIdle;
            tx_pop  = 1'b0;
        end
    end

    always_comb begin
        TX = 1'b1;
        unique case (tx_st_q)
            StStart:  TX = 1'b0;
            StData:   TX = tx_sh_q[0];
            StParity: TX = tx_par_q;
            default:  TX = 1'b1;
        endcase
    end

    // ---------------- RX FSM ----------------
    state_e           rx_st_q, rx_st_d;
    logic [3:0]       rx_tk_q, rx_tk_d, rx_bit_q, rx_bit_d, rx_nb_q, rx_nb_d;
    logic             rx_s1_q, rx_s2_q, rx_s3_q, rx_fall, rx_tick, rx_vote;
    logic             rx_v7_q, rx_v7_d, rx_v8_q, rx_v8_d;
    logic             rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d;
    logic             fe_set, pe_set, ovf_set;
    logic [DIV_W-1:0] rx_div_q, rx_div_d, rx_pre_q, rx_pre_d;

    assign rx_fall = rx_s3_q & ~rx_s2_q;
    assign rx_vote = (rx_v7_q & rx_v8_q) | (rx_v7_q & rx_s2_q) | (rx_v8_q & rx_s2_q);
    assign ovf_set = rx_push_req && rx_full && !rx_pop;

    always_comb begin
        rx_st_d     = rx_st_q;
        rx_tk_d     = rx_tk_q;
        rx_bit_d    = rx_bit_q;
        rx_nb_d     = rx_nb_q;
        rx_data_d   = rx_data_q;
        rx_v7_d     = rx_v7_q;
        rx_v8_d     = rx_v8_q;
        rx_pen_d    = rx_pen_q;
        rx_podd_d   = rx_podd_q;
        rx_div_d    = rx_div_q;
        rx_pre_d    = rx_pre_q;
        rx_push_req = 1'b0;
        fe_set      = 1'b0;
        pe_set      = 1'b0;
        rx_tick     = (rx_pre_q == '0);
        if (rx_st_q != StIdle) begin
            rx_pre_d = rx_tick ? rx_div_q : rx_pre_q - 1'b1;
            if (rx_tick) begin
                rx_tk_d = rx_tk_q + 1'b1;
                if (rx_tk_q == 4'd7) rx_v7_d = rx_s2_q;
                if (rx_tk_q == 4'd8) rx_v8_d = rx_s2_q;
            end
        end
        unique case (rx_st_q)
            StIdle: begin
                if (rx_fall) begin
                    rx_st_d   = StStart;
                    rx_tk_d   = '0;
                    rx_pre_d  = div_q;
                    rx_div_d  = div_q;
                    rx_data_d = '0;
                    rx_nb_d   = word_len(ctrl_q[3:1]);
                    rx_pen_d  = ctrl_q[5];
                    rx_podd_d = ctrl_q[6];
                end
            end
            StStart: begin
                if (rx_tick && rx_tk_q == 4'd9 && rx_vote) rx_st_d = StIdle;
                else if (rx_tick && rx_tk_q == 4'd15) begin
                    rx_st_d  = StData;
                    rx_bit_d = '0;
                end
            end
            StData: begin
                if (rx_tick && rx_tk_q == 4'd9)
                    rx_data_d = rx_data_q | (DATA_W'(rx_vote) << rx_bit_q);
                if (rx_tick && rx_tk_q == 4'd15) begin
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == rx_nb_q - 4'd1) rx_st_d = rx_pen_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (rx_tick && rx_tk_q == 4'd9) pe_set = rx_vote ^ (^rx_data_q) ^ rx_podd_q;
                if (rx_tick && rx_tk_q == 4'd15) rx_st_d = StStop;
            end
            StStop: begin
                // Only the first stop bit is checked; returning mid-bit catches back-to-back frames.
                if (rx_tick && rx_tk_q == 4'd9) begin
                    rx_push_req = 1'b1;
                    fe_set      = ~rx_vote;
                    rx_st_d     = StIdle;
                end
            end
            default: rx_st_d = StIdle;
        endcase
        if (!en) begin
            rx_st_d     = StIdle;
            rx_push_req = 1'b0;
            fe_set      = 1'b0;
            pe_set      = 1'b0;
        end
    end

    // ---------------- state, registers, bus ----------------
    logic [31:0] rd_mux;

    assign stat = {par_err_q, frame_err_q, rx_ovf_q, !tx_nempty && (tx_st_q == StIdle), rx_nempty};
    assign intr = |(stat & ctrl_q[11:7]);

    always_comb begin
        rd_mux = '0;
        case (sel)
            3'd0:    rd_mux = 32'(ctrl_q);
            3'd1:    rd_mux = 32'(stat);
            3'd3:    if (rx_nempty) rd_mux = 32'(rx_mem[rx_rp_q]);
            3'd4:    rd_mux = 32'(div_q);
            3'd5:    rd_mux = {16'(tx_cnt_q), 16'(rx_cnt_q)};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= '0;
            div_q       <= '0;
            rx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            rdata       <= '0;
            tx_st_q     <= StIdle;
            tx_tk_q     <= '0;
            tx_bit_q    <= '0;
            tx_nb_q     <= '0;
            tx_sh_q     <= '0;
            tx_par_q    <= 1'b0;
            tx_pen_q    <= 1'b0;
            tx_s2_q     <= 1'b0;
            tx_stop_q   <= 1'b0;
            tx_div_q    <= '0;
            tx_pre_q    <= '0;
            rx_st_q     <= StIdle;
            rx_tk_q     <= '0;
            rx_bit_q    <= '0;
            rx_nb_q     <= '0;
            rx_data_q   <= '0;
            rx_v7_q     <= 1'b0;
            rx_v8_q     <= 1'b0;
            rx_pen_q    <= 1'b0;
            rx_podd_q   <= 1'b0;
            rx_div_q    <= '0;
            rx_pre_q    <= '0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
        end else begin
            if (wr_req && sel == 3'd0) ctrl_q <= wdata[11:0];
            if (wr_req && sel == 3'd4) div_q  <= wdata[DIV_W-1:0];
            // Hardware set takes priority over a simultaneous W1C.
            rx_ovf_q    <= ovf_set | (rx_ovf_q    & ~(w1c & wdata[2]));
            frame_err_q <= fe_set  | (frame_err_q & ~(w1c & wdata[3]));
            par_err_q   <= pe_set  | (par_err_q   & ~(w1c & wdata[4]));
            if (rd_req) rdata <= rd_mux;
            tx_st_q     <= tx_st_d;
            tx_tk_q     <= tx_tk_d;
            tx_bit_q    <= tx_bit_d;
            tx_nb_q     <= tx_nb_d;
            tx_sh_q     <= tx_sh_d;
            tx_par_q    <= tx_par_d;
            tx_pen_q    <= tx_pen_d;
            tx_s2_q     <= tx_s2_d;
            tx_stop_q   <= tx_stop_d;
            tx_div_q    <= tx_div_d;
            tx_pre_q    <= tx_pre_d;
            rx_st_q     <= rx_st_d;
            rx_tk_q     <= rx_tk_d;
            rx_bit_q    <= rx_bit_d;
            rx_nb_q     <= rx_nb_d;
            rx_data_q   <= rx_data_d;
            rx_v7_q     <= rx_v7_d;
            rx_v8_q     <= rx_v8_d;
            rx_pen_q    <= rx_pen_d;
            rx_podd_q   <= rx_podd_d;
            rx_div_q    <= rx_div_d;
            rx_pre_q    <= rx_pre_d;
            rx_s1_q     <= RX;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: register vector table, TX waveform, loopback, error flags,
// overflow, glitch rejection, TX-full drop and asynchronous reset mid-frame.
module tb_uart_fifo_core;
    localparam logic [31:0] A_CTRL = 32'h00;
    localparam logic [31:0] A_STAT = 32'h04;
    localparam logic [31:0] A_TXD  = 32'h08;
    localparam logic [31:0] A_RXD  = 32'h0C;
    localparam logic [31:0] A_DIV  = 32'h10;
    localparam logic [31:0] A_LVL  = 32'h14;

    logic        clk = 1'b0;
    logic        reset_n, tx_line, rx_line, cs, wen, intr;
    logic        loopback, rx_drv;
    logic [31:0] addr, wdata, rdata;
    int          total = 0;
    int          bad = 0;
    logic [31:0] sb_q [$];

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        exp_intr;
    } vec_t;
    vec_t vecs [14];

    uart_fifo_core #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .TX(tx_line), .RX(rx_line), .cs(cs), .wen(wen),
        .addr(addr), .wdata(wdata), .rdata(rdata), .intr(intr)
    );

    always #5 clk = ~clk;
    assign rx_line = loopback ? tx_line : rx_drv;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wen = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wen = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = rdata;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic pop_check(input string name, input logic [31:0] act);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got 0x%08h with no expected value queued", name, act);
        end else begin
            check(name, act, sb_q.pop_front());
        end
    endtask

    task automatic rxd_pop_check(input string name);
        logic [31:0] d;
        bus_read(A_RXD, d);
        pop_check(name, d);
    endtask

    task automatic wait_rx_level(input string name, input int exp, input int budget);
        logic [31:0] d;
        int n = 0;
        do begin
            bus_read(A_LVL, d);
            n++;
        end while (d[15:0] != 16'(exp) && n < budget);
        check(name, 32'(d[15:0]), 32'(exp));
    endtask

    // Drives one 8-bit frame on RX, optional even parity, given stop level.
    task automatic send_rx(input logic [7:0] data, input bit pen, input bit stopv,
                           input int bitclk);
        rx_drv = 1'b0;
        repeat (bitclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = data[i];
            repeat (bitclk) @(negedge clk);
        end
        if (pen) begin
            rx_drv = ^data;
            repeat (bitclk) @(negedge clk);
        end
        rx_drv = stopv;
        repeat (bitclk) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bitclk) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  txb;
        logic [7:0]  lb_words [3];
        logic [7:0]  v;
        logic [31:0] d;
        int          k;

        reset_n = 1'b0; cs = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
        loopback = 1'b0; rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_line), 32'd1);
        check("reset_rdata", rdata, 32'd0);
        check("reset_intr", 32'(intr), 32'd0);
        reset_n = 1'b1;
        read_check("reset_stat", A_STAT, 32'h2);

        // Register vectors: writes check intr only, reads check rdata and intr.
        vecs[0]  = '{1'b1, A_DIV,  32'h0000_1234, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, A_DIV,  32'h0,         32'h0000_1234, 1'b0};
        vecs[2]  = '{1'b1, A_DIV,  32'h000A_BCDE, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, A_DIV,  32'h0,         32'h0000_BCDE, 1'b0};
        vecs[4]  = '{1'b1, A_CTRL, 32'hFFFF_F07E, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, A_CTRL, 32'h0,         32'h0000_007E, 1'b0};
        vecs[6]  = '{1'b1, A_CTRL, 32'h0000_0100, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, A_STAT, 32'h0,         32'h0000_0002, 1'b1};
        vecs[8]  = '{1'b1, A_CTRL, 32'h0000_0080, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h18, 32'h0,         32'h0,         1'b0};
        vecs[10] = '{1'b1, 32'h1C, 32'h0000_FFFF, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'h1C, 32'h0,         32'h0,         1'b0};
        vecs[12] = '{1'b0, A_RXD,  32'h0,         32'h0,         1'b0};
        vecs[13] = '{1'b0, A_LVL,  32'h0,         32'h0,         1'b0};
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].a, vecs[i].d);
            end else begin
                bus_read(vecs[i].a, d);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
            end
            check($sformatf("vec%0d_intr", i), 32'(intr), 32'(vecs[i].exp_intr));
        end

        // TX waveform of 0xA5, 8N1, DIV=0.
        bus_write(A_DIV, 32'h0);
        bus_write(A_CTRL, 32'h7);
        txb = 8'hA5;
        for (int i = 0; i < 8; i++) sb_q.push_back(32'(txb[i]));
        sb_q.push_back(32'd1);
        bus_write(A_TXD, 32'hA5);
        k = 0;
        while (tx_line !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        check("tx_start_seen", 32'(tx_line), 32'd0);
        k = 0;
        while (tx_line === 1'b0 && k < 40) begin @(negedge clk); k++; end
        check("tx_start_len", 32'(k), 32'd16);
        for (int i = 0; i < 9; i++) begin
            repeat (8) @(negedge clk);
            pop_check($sformatf("tx_bit%0d", i), 32'(tx_line));
            repeat (8) @(negedge clk);
        end
        read_check("tx_empty_after", A_STAT, 32'h2);

        // Loopback, 8E2.
        bus_write(A_CTRL, 32'h37);
        loopback = 1'b1;
        lb_words[0] = 8'h00; lb_words[1] = 8'hFF; lb_words[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(32'(lb_words[i]));
            bus_write(A_TXD, 32'(lb_words[i]));
        end
        wait_rx_level("lb_level", 3, 600);
        for (int i = 0; i < 3; i++) rxd_pop_check($sformatf("lb_word%0d", i));
        repeat (60) @(negedge clk);
        read_check("lb_stat", A_STAT, 32'h2);
        loopback = 1'b0;

        // Frame error with IE[3], then W1C.
        bus_write(A_CTRL, 32'h407);
        sb_q.push_back(32'h3C);
        send_rx(8'h3C, 1'b0, 1'b0, 16);
        read_check("fe_stat", A_STAT, 32'h0B);
        check("fe_intr", 32'(intr), 32'd1);
        bus_write(A_STAT, 32'h08);
        read_check("fe_stat_clr", A_STAT, 32'h03);
        check("fe_intr_clr", 32'(intr), 32'd0);
        rxd_pop_check("fe_word");

        // 2-clk glitch with DIV=3, then a real frame at that rate.
        bus_write(A_CTRL, 32'h7);
        bus_write(A_DIV, 32'h3);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        read_check("glitch_lvl", A_LVL, 32'h0);
        sb_q.push_back(32'h96);
        send_rx(8'h96, 1'b0, 1'b1, 64);
        rxd_pop_check("glitch_next_word");
        bus_write(A_DIV, 32'h0);

        // RX overflow: 17 frames, no reads.
        for (int i = 0; i < 17; i++) begin
            v = 8'((i * 37 + 5) & 255);
            if (i < 16) sb_q.push_back(32'(v));
            send_rx(v, 1'b0, 1'b1, 16);
        end
        read_check("ovf_lvl", A_LVL, 32'h0000_0010);
        read_check("ovf_stat", A_STAT, 32'h07);
        for (int i = 0; i < 16; i++) rxd_pop_check($sformatf("ovf_word%0d", i));
        read_check("ovf_lvl_drained", A_LVL, 32'h0);

        // TX FIFO full drop, then reset in the middle of a frame.
        bus_write(A_CTRL, 32'h200);
        check("full_intr", 32'(intr), 32'd1);
        for (int i = 0; i < 17; i++) bus_write(A_TXD, 32'h0);
        read_check("txfull_lvl", A_LVL, 32'h0010_0000);
        bus_write(A_CTRL, 32'h207);
        k = 0;
        while (tx_line !== 1'b0 && k < 100) begin @(negedge clk); k++; end
        check("rst_frame_started", 32'(tx_line), 32'd0);
        read_check("rst_lvl_before", A_LVL, 32'h000F_0000);
        reset_n = 1'b0;
        #1;
        check("rst_tx", 32'(tx_line), 32'd1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_intr", 32'(intr), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("rst_lvl", A_LVL, 32'h0);
        read_check("rst_stat", A_STAT, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
